// File: rtl/acq_sample_fifo.sv
// Sample FIFO for acq_ctrl: buffers samples during the acquisition window, streams them out with a last tag.
// Optional build macro ACQ_FIFO_STATS_EN adds a saturating drop_cnt output.
module acq_sample_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acq_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty,
`ifdef ACQ_FIFO_STATS_EN
    output logic [15:0]       drop_cnt,
`endif
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t              r_state;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_level;
    logic                r_overflow;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_out_valid;
    logic w_wr;
    logic w_drop;
    logic w_pop;
    logic w_start;

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);

    // The newest entry is held back during capture so the last tag can be placed once the window closes.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_out_valid = 1'b0;
        case (r_state)
            S_CAPTURE: w_out_valid = (r_level > LVL_ONE);
            S_DRAIN:   w_out_valid = !w_empty;
            default:   w_out_valid = 1'b0;
        endcase
    end

    assign w_wr    = acq_en & in_valid & ~w_full & (r_state != S_DRAIN);
    assign w_drop  = acq_en & in_valid & ~w_wr;
    assign w_pop   = w_out_valid & out_ready;
    assign w_start = (r_state == S_IDLE) & acq_en;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;

            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase

            if (w_drop)       r_overflow <= 1'b1;
            else if (w_start) r_overflow <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (acq_en) r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!acq_en) r_state <= w_empty ? S_IDLE : S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pop && r_level == LVL_ONE) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the sample array is not reset; out_data is masked while out_valid is low instead.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= in_data;
    end

`ifdef ACQ_FIFO_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_start)                  r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_last  = w_out_valid & (r_state == S_DRAIN) & (r_level == LVL_ONE);
    assign level     = r_level;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;

endmodule
